// File: rtl/iddmm_div_pkg.sv
// Shared definitions for the 512-by-256 restoring divider.
package iddmm_div_pkg;

  localparam int DIV_W = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } div_state_t;

  // Quotient reported on divide-by-zero or quotient overflow.
  localparam logic [DIV_W-1:0] ERR_QUOTIENT = '1;

endpackage

// File: rtl/iddmm_div_step.sv
// One radix-2 restoring step: shift in the next dividend bit, then
// compare-subtract against the divisor.
module iddmm_div_step
  import iddmm_div_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic [W:0]   i_r,
  input  logic         i_s_msb,
  input  logic [W-1:0] i_divisor,
  output logic [W:0]   o_next_r,
  output logic         o_bit
);

  logic [W+1:0] w_t;
  logic [W:0]   w_diff;
  logic         w_ge;

  // The partial remainder is always below the divisor, so i_r[W] is zero and
  // w_t[W:0] is the shifted value; keeping the full width makes the compare
  // safe even if that ever stopped holding.
  assign w_t      = {i_r, i_s_msb};
  assign w_ge     = (w_t >= {2'b00, i_divisor});
  assign w_diff   = w_t[W:0] - {1'b0, i_divisor};
  assign o_next_r = w_ge ? w_diff : w_t[W:0];
  assign o_bit    = w_ge;

endmodule

// File: rtl/iddmm_div_512_to_256.sv
// Iterative radix-2 restoring divider: 2W-bit dividend / W-bit divisor.
//
//   state | meaning
//   IDLE  | ready for operands
//   CHECK | screen divide-by-zero / quotient overflow
//   RUN   | W compare-subtract iterations
//   DONE  | result held until consumer accepts it
module iddmm_div_512_to_256
  import iddmm_div_pkg::*;
#(
  parameter int W  = DIV_W,
  parameter int CW = $clog2(W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*W-1:0]   dividend,
  input  logic [W-1:0]     divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     quotient,
  output logic [W-1:0]     remainder,
  output logic             err
);

  div_state_t      r_state;
  div_state_t      w_state_nxt;
  logic [W:0]      r_r;
  logic [W-1:0]    r_s;
  logic [W-1:0]    r_divisor;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_quotient;
  logic [W-1:0]    r_remainder;
  logic            r_err;
  logic [W:0]      w_next_r;
  logic            w_bit;
  logic            w_last;
  logic            w_bad;
  logic            w_in_ready;
  logic            w_out_valid;

  iddmm_div_step #(.W(W)) u_step (
    .i_r       (r_r),
    .i_s_msb   (r_s[W-1]),
    .i_divisor (r_divisor),
    .o_next_r  (w_next_r),
    .o_bit     (w_bit)
  );

  // A quotient only fits in W bits when the dividend's high half is below the divisor.
  assign w_last = (r_cnt == CW'(W-1));
  assign w_bad  = (r_divisor == '0) || (r_r >= {1'b0, r_divisor});

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) w_state_nxt = CHECK;
      end
      CHECK:   w_state_nxt = w_bad ? DONE : RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE: begin
        w_out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_r         <= '0;
      r_s         <= '0;
      r_divisor   <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_err       <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_r       <= {1'b0, dividend[2*W-1:W]};
            r_s       <= dividend[W-1:0];
            r_divisor <= divisor;
          end
        end
        CHECK: begin
          if (w_bad) begin
            r_err       <= 1'b1;
            r_quotient  <= W'(ERR_QUOTIENT);
            r_remainder <= '0;
          end else begin
            r_cnt <= '0;
          end
        end
        RUN: begin
          r_r   <= w_next_r;
          r_s   <= {r_s[W-2:0], w_bit};
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_quotient  <= {r_s[W-2:0], w_bit};
            r_remainder <= w_next_r[W-1:0];
            r_err       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign err       = r_err;

endmodule

// File: tb/tb_iddmm_div_512_to_256.sv
// Self-checking bench for iddmm_div_512_to_256 against an arithmetic model.
module tb_iddmm_div_512_to_256;

  localparam int W = 256;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           err;

  int n_pass  = 0;
  int n_total = 0;

  iddmm_div_512_to_256 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp_v);
    n_total++;
    if (got === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp_v);
  endtask

  function automatic logic [W-1:0] rand256();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < W/32; i++) v = {v[W-33:0], $urandom()};
    return v;
  endfunction

  // Reference: plain integer division with the error rules applied up front.
  function automatic void model(input logic [2*W-1:0] dd, input logic [W-1:0] dv,
                                output logic [W-1:0] q, output logic [W-1:0] r, output logic e);
    logic [2*W-1:0] dv_w;
    dv_w = {{W{1'b0}}, dv};
    if (dv == '0 || dd[2*W-1:W] >= dv) begin
      q = '1; r = '0; e = 1'b1;
    end else begin
      q = W'(dd / dv_w);
      r = W'(dd % dv_w);
      e = 1'b0;
    end
  endfunction

  // Waits (bounded) for in_ready, presents operands, completes the input handshake.
  task automatic start_div(input logic [2*W-1:0] dd, input logic [W-1:0] dv);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_wait", {511'b0, in_ready}, 512'd1);
    dividend = dd;
    divisor  = dv;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Counts cycles from the input handshake until out_valid is seen.
  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 400);
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({tag, "_in_ready_after"}, {511'b0, in_ready}, 512'd1);
  endtask

  task automatic do_and_check(input string tag, input logic [2*W-1:0] dd, input logic [W-1:0] dv,
                              input logic [W-1:0] eq, input logic [W-1:0] er, input logic ee);
    int lat;
    start_div(dd, dv);
    wait_result(lat);
    check({tag, "_valid"}, {511'b0, out_valid}, 512'd1);
    check({tag, "_q"}, {{W{1'b0}}, quotient}, {{W{1'b0}}, eq});
    check({tag, "_r"}, {{W{1'b0}}, remainder}, {{W{1'b0}}, er});
    check({tag, "_err"}, {511'b0, err}, {511'b0, ee});
    check({tag, "_lat"}, 512'(lat), 512'(ee ? 2 : W + 2));
    release_result(tag);
  endtask

  initial begin
    logic [W-1:0]   x, y, mq, mr, all1, hi;
    logic [2*W-1:0] dd, dd2;
    logic           me, seen;
    int             lat;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", {511'b0, in_ready}, 512'd1);
    check("rst_out_valid", {511'b0, out_valid}, 512'd0);
    check("rst_q", {{W{1'b0}}, quotient}, 512'd0);
    check("rst_r", {{W{1'b0}}, remainder}, 512'd0);
    check("rst_err", {511'b0, err}, 512'd0);

    all1 = '1;
    do_and_check("small", 512'd100, 256'd7, 256'd14, 256'd2, 1'b0);
    do_and_check("maxsq", {{W{1'b0}}, all1} * {{W{1'b0}}, all1}, all1, all1, '0, 1'b0);
    do_and_check("div0", 512'd12345, '0, all1, '0, 1'b1);
    dd = 512'd5 << W;
    do_and_check("ovf", dd, 256'd5, all1, '0, 1'b1);
    x = 256'd1 << (W-1);
    do_and_check("half", {{W{1'b0}}, all1}, x, 256'd1, x - 256'd1, 1'b0);
    do_and_check("lt", 512'd5, 256'd9, '0, 256'd5, 1'b0);
    x = rand256();
    do_and_check("div1", {{W{1'b0}}, x}, 256'd1, x, '0, 1'b0);

    for (int i = 0; i < 100; i++) begin
      x = rand256();
      y = rand256() >> $urandom_range(0, W-1);
      if (y == '0) y = 256'd1;
      dd = {{W{1'b0}}, x} * {{W{1'b0}}, y};
      do_and_check($sformatf("rt%0d", i), dd, y, x, '0, 1'b0);
    end

    for (int i = 0; i < 16; i++) begin
      y = rand256() >> $urandom_range(0, W-1);
      hi = (i % 4 == 0) ? rand256() : ((y == '0) ? '0 : rand256() % y);
      dd = {hi, rand256()};
      model(dd, y, mq, mr, me);
      do_and_check($sformatf("rnd%0d", i), dd, y, mq, mr, me);
    end

    // Backpressure, with the next operands already waiting during DONE.
    dd  = 512'd987654321;
    dd2 = 512'd1000001;
    start_div(dd, 256'd1000);
    wait_result(lat);
    check("bp_lat", 512'(lat), 512'(W + 2));
    dividend = dd2; divisor = 256'd10; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("bp_valid%0d", i), {511'b0, out_valid}, 512'd1);
      check($sformatf("bp_q%0d", i), {{W{1'b0}}, quotient}, 512'd987654);
      check($sformatf("bp_r%0d", i), {{W{1'b0}}, remainder}, 512'd321);
      check($sformatf("bp_in_ready%0d", i), {511'b0, in_ready}, 512'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("bp_in_ready_rise", {511'b0, in_ready}, 512'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("bp2_in_ready_low", {511'b0, in_ready}, 512'd0);
    wait_result(lat);
    check("bp2_q", {{W{1'b0}}, quotient}, 512'd100000);
    check("bp2_r", {{W{1'b0}}, remainder}, 512'd1);
    check("bp2_err", {511'b0, err}, 512'd0);
    check("bp2_lat", 512'(lat), 512'(W + 2));
    release_result("bp2");

    // Reset 100 cycles into a division.
    start_div(512'd1000000, 256'd7);
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mrst_out_valid", {511'b0, out_valid}, 512'd0);
    check("mrst_q", {{W{1'b0}}, quotient}, 512'd0);
    check("mrst_r", {{W{1'b0}}, remainder}, 512'd0);
    check("mrst_err", {511'b0, err}, 512'd0);
    @(negedge clk);
    rst = 1'b0;
    check("mrst_in_ready", {511'b0, in_ready}, 512'd1);
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("mrst_no_stale", {511'b0, seen}, 512'd0);
    do_and_check("after_rst", 512'd1000, 256'd3, 256'd333, 256'd1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
